// File: rtl/bist_pkg.sv
// bist_pkg -- shared definitions for the logic BIST engine.
//   bist_state_e : controller state encoding
//   DEF_*        : default generator / compactor polynomials and seed
//   bist_latency : cycles from the edge that samples bist_start to bist_end
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } bist_state_e;

  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'h0001;
  localparam logic [15:0] DEF_MISR_POLY = 16'hB400;

  // INIT + COMPARE, one shift+capture per pattern, then the final unload.
  function automatic int unsigned bist_latency(input int unsigned n_patterns,
                                               input int unsigned chain_len);
    return 2 + n_patterns * (chain_len + 1) + chain_len;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr -- left-shifting Fibonacci shift register, used both as the
// pattern generator (PAR_EN = 0) and as the MISR compactor (PAR_EN = 1).
// Feedback bit = XOR of the state bits selected by POLY, inserted at bit 0.
// With PAR_EN the zero-extended din is XORed into the shifted value.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (state = SEED)
//   init     : load SEED (wins over step)
//   step     : advance one position
//   din      : parallel input (ignored unless PAR_EN)
//   state_o  : low OUT_W bits of the register
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int          W      = 16,
  parameter logic [W-1:0] POLY  = W'(DEF_LFSR_POLY),
  parameter logic [W-1:0] SEED  = W'(DEF_LFSR_SEED),
  parameter bit          PAR_EN = 1'b0,
  parameter int          DIN_W  = 1,
  parameter int          OUT_W  = W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic [DIN_W-1:0] din,
  output logic [OUT_W-1:0] state_o
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic [W-1:0] par_in;

  always_comb begin
    par_in = '0;
    if (PAR_EN) par_in[DIN_W-1:0] = din;
    state_d = state_q;
    if (init) begin
      state_d = SEED;
    end else if (step) begin
      state_d = {state_q[W-2:0], ^(state_q & POLY)} ^ par_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/bist_engine.sv
// bist_engine -- logic BIST controller: drives N_CHAINS scan chains with
// LFSR patterns, compacts the responses in a MISR and compares the final
// signature against GOLDEN_SIG.
// Ports:
//   CLK, RST    : clock (rising edge), asynchronous active-high reset
//   bist_start  : level request to run a test
//   scan_en     : 1 = chains shift, 0 = capture
//   scan_in     : serial data into the chains
//   scan_out    : serial data out of the chains
//   bist_busy   : test in progress (INIT .. COMPARE)
//   bist_end    : test complete, pass_fail valid (DONE)
//   pass_fail   : 1 = signature matched GOLDEN_SIG
// Optional (macro BIST_SIG_OUT_EN):
//   signature   : live MISR contents (frozen from COMPARE until next INIT)
//   pattern_cnt : patterns applied so far
module bist_engine
  import bist_pkg::*;
#(
  parameter int N_CHAINS   = 2,
  parameter int CHAIN_LEN  = 16,
  parameter int N_PATTERNS = 256,
  parameter int LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(DEF_LFSR_POLY),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEF_LFSR_SEED),
  parameter int MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEF_MISR_POLY),
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                bist_start,
  output logic                scan_en,
  output logic [N_CHAINS-1:0] scan_in,
  input  logic [N_CHAINS-1:0] scan_out,
  output logic                bist_busy,
  output logic                bist_end,
  output logic                pass_fail
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [MISR_W-1:0]   signature,
  output logic [$clog2(N_PATTERNS+1)-1:0] pattern_cnt
`endif
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] LAST_PAT = PW'(N_PATTERNS - 1);

  bist_state_e state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pat_cnt_q, pat_cnt_d;
  logic          pass_fail_q, pass_fail_d;

  logic                lfsr_init, lfsr_step;
  logic                misr_init, misr_step;
  logic [N_CHAINS-1:0] lfsr_bits;
  logic [MISR_W-1:0]   misr_sig;

  bist_lfsr #(
    .W(LFSR_W), .POLY(LFSR_POLY), .SEED(LFSR_SEED),
    .PAR_EN(1'b0), .DIN_W(N_CHAINS), .OUT_W(N_CHAINS)
  ) u_lfsr (
    .clk(CLK), .rst(RST), .init(lfsr_init), .step(lfsr_step),
    .din('0), .state_o(lfsr_bits)
  );

  bist_lfsr #(
    .W(MISR_W), .POLY(MISR_POLY), .SEED('0),
    .PAR_EN(1'b1), .DIN_W(N_CHAINS), .OUT_W(MISR_W)
  ) u_misr (
    .clk(CLK), .rst(RST), .init(misr_init), .step(misr_step),
    .din(scan_out), .state_o(misr_sig)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_fail_d = pass_fail_q;
    lfsr_init   = 1'b0;
    lfsr_step   = 1'b0;
    misr_init   = 1'b0;
    misr_step   = 1'b0;
    scan_en     = 1'b0;
    scan_in     = '0;
    bist_busy   = 1'b0;
    bist_end    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bist_start) state_d = ST_INIT;
      end
      ST_INIT: begin
        bist_busy   = 1'b1;
        lfsr_init   = 1'b1;
        misr_init   = 1'b1;
        bit_cnt_d   = '0;
        pat_cnt_d   = '0;
        pass_fail_d = 1'b0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        bist_busy = 1'b1;
        scan_en   = 1'b1;
        scan_in   = lfsr_bits;
        lfsr_step = 1'b1;
        // The first pattern's shift only fills the chains; what comes out
        // is pre-test garbage and must not reach the signature.
        misr_step = (pat_cnt_q != '0);
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_CAPTURE: begin
        bist_busy = 1'b1;
        pat_cnt_d = pat_cnt_q + PW'(1);
        state_d   = (pat_cnt_q == LAST_PAT) ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        bist_busy = 1'b1;
        scan_en   = 1'b1;
        misr_step = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = ST_COMPARE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_COMPARE: begin
        bist_busy   = 1'b1;
        pass_fail_d = (misr_sig == GOLDEN_SIG);
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        bist_end = 1'b1;
        if (!bist_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      pat_cnt_q   <= '0;
      pass_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_fail_q <= pass_fail_d;
    end
  end

  assign pass_fail = pass_fail_q;

`ifdef BIST_SIG_OUT_EN
  assign signature   = misr_sig;
  assign pattern_cnt = pat_cnt_q;
`endif

endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine -- bench for bist_engine with N_CHAINS=2, CHAIN_LEN=4,
// N_PATTERNS=8. The circuit under test is two 4-flop scan chains with a
// small capture logic; chain 1 flop 2 can be made stuck-at-0.
// Define BIST_SIG_OUT_EN to also check signature / pattern_cnt.
module tb_bist_engine;

  // Whole-run reference: generator, chains and compactor stepped cycle by
  // cycle, returning the final signature.
  function automatic logic [15:0] model_sig(input bit fault);
    logic [15:0] l, m;
    logic [3:0]  c0, c1, n0, n1;
    logic [1:0]  si, so;
    l = 16'h0001; m = 16'h0000; c0 = 4'h0; c1 = 4'h0;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 4; k++) begin
        si = l[1:0];
        so = {c1[3], c0[3]};
        if (p != 0) m = {m[14:0], ^(m & 16'hB400)} ^ {14'd0, so};
        c0 = {c0[2:0], si[0]};
        c1 = {c1[2:0], si[1]};
        if (fault) c1[2] = 1'b0;
        l = {l[14:0], ^(l & 16'hB400)};
      end
      n0 = c0 ^ {c1[2:0], c1[3]};
      n1 = (c0 & ~c1) ^ {c1[0], c1[3:1]};
      c0 = n0;
      c1 = n1;
      if (fault) c1[2] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      so = {c1[3], c0[3]};
      m  = {m[14:0], ^(m & 16'hB400)} ^ {14'd0, so};
      c0 = {c0[2:0], 1'b0};
      c1 = {c1[2:0], 1'b0};
      if (fault) c1[2] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD = model_sig(1'b0);
  localparam logic [15:0] BAD  = model_sig(1'b1);

  logic       CLK = 1'b0;
  logic       RST;
  logic       bist_start;
  logic       scan_en;
  logic [1:0] scan_in;
  logic [1:0] scan_out;
  logic       bist_busy;
  logic       bist_end;
  logic       pass_fail;
`ifdef BIST_SIG_OUT_EN
  logic [15:0] signature;
  logic [3:0]  pattern_cnt;
`endif

  logic [3:0] c0 = 4'h0;
  logic [3:0] c1 = 4'h0;
  logic       fault_en = 1'b0;
  logic [3:0] fmask;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int hold_bad;

  typedef struct packed {
    logic        fault;
    logic        toggle;
    logic [7:0]  exp_lat;
    logic        exp_pass;
    logic [15:0] exp_sig;
  } vec_t;
  vec_t vecs [4];

  bist_engine #(
    .N_CHAINS(2), .CHAIN_LEN(4), .N_PATTERNS(8), .GOLDEN_SIG(GOLD)
  ) dut (
    .CLK(CLK), .RST(RST), .bist_start(bist_start),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .bist_busy(bist_busy), .bist_end(bist_end), .pass_fail(pass_fail)
`ifdef BIST_SIG_OUT_EN
    , .signature(signature), .pattern_cnt(pattern_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Scan chains: shift when scan_en, otherwise capture.
  assign fmask    = fault_en ? 4'b1011 : 4'b1111;
  assign scan_out = {c1[3], c0[3]};
  always @(posedge CLK) begin
    if (scan_en) begin
      c0 <= {c0[2:0], scan_in[0]};
      c1 <= {c1[2:0], scan_in[1]} & fmask;
    end else begin
      c0 <= c0 ^ {c1[2:0], c1[3]};
      c1 <= ((c0 & ~c1) ^ {c1[0], c1[3:1]}) & fmask;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // bist_start must already be high; counts edges after the sampling edge.
  task automatic run_to_end(input bit toggle, output int cyc);
    @(posedge CLK);
    cyc = 0;
    while (!bist_end && cyc < 200) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (toggle) bist_start = (cyc >= 40) || (cyc % 3 != 0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'd46, 1'b1, GOLD};
    vecs[1] = '{1'b1, 1'b0, 8'd46, 1'b0, BAD};
    vecs[2] = '{1'b0, 1'b1, 8'd46, 1'b1, GOLD};
    vecs[3] = '{1'b1, 1'b1, 8'd46, 1'b0, BAD};

    RST = 1'b1;
    bist_start = 1'b0;
    #12;
    check("reset_outputs", {27'd0, scan_en, scan_in, bist_busy, bist_end, pass_fail}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_after_reset", {30'd0, bist_busy, bist_end}, 32'd0);
    while ($time < 300) @(negedge CLK);

    for (int i = 0; i < 4; i++) begin
      fault_en   = vecs[i].fault;
      bist_start = 1'b1;
      run_to_end(vecs[i].toggle, lat);
      check($sformatf("v%0d_latency", i), lat, {24'd0, vecs[i].exp_lat});
      check($sformatf("v%0d_pass_fail", i), {31'd0, pass_fail}, {31'd0, vecs[i].exp_pass});
      check($sformatf("v%0d_done_outputs", i), {28'd0, scan_en, scan_in, bist_busy}, 32'd0);
`ifdef BIST_SIG_OUT_EN
      check($sformatf("v%0d_signature", i), {16'd0, signature}, {16'd0, vecs[i].exp_sig});
      check($sformatf("v%0d_pattern_cnt", i), {28'd0, pattern_cnt}, 32'd8);
`endif
      @(negedge CLK);
      bist_start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check($sformatf("v%0d_end_cleared", i), {30'd0, bist_end, bist_busy}, 32'd0);
      check($sformatf("v%0d_pass_kept", i), {31'd0, pass_fail}, {31'd0, vecs[i].exp_pass});
    end

    // bist_start held after DONE: no second run, then drop/raise reruns.
    fault_en   = 1'b0;
    bist_start = 1'b1;
    run_to_end(1'b0, lat);
    check("hold_first_latency", lat, 32'd46);
    hold_bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (!bist_end || bist_busy || scan_en || pass_fail !== 1'b1) hold_bad++;
    end
    check("hold_no_rerun", hold_bad, 32'd0);
    bist_start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("hold_drop_end", {31'd0, bist_end}, 32'd0);
    bist_start = 1'b1;
    run_to_end(1'b0, lat);
    check("second_run_latency", lat, 32'd46);
    check("second_run_pass", {31'd0, pass_fail}, 32'd1);
    @(negedge CLK);
    bist_start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    // Reset pulse during the third pattern's shift.
    bist_start = 1'b1;
    @(posedge CLK);
    repeat (12) @(posedge CLK);
    #3;
    check("pre_reset_shifting", {30'd0, scan_en, bist_busy}, 32'd3);
    RST = 1'b1;
    bist_start = 1'b0;
    #1;
    check("mid_reset_outputs", {27'd0, scan_en, scan_in, bist_busy, bist_end, pass_fail}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("held_reset_outputs", {27'd0, scan_en, scan_in, bist_busy, bist_end, pass_fail}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("post_reset_idle", {31'd0, bist_busy}, 32'd0);
    bist_start = 1'b1;
    run_to_end(1'b0, lat);
    check("rerun_latency", lat, 32'd46);
    check("rerun_pass", {31'd0, pass_fail}, 32'd1);
`ifdef BIST_SIG_OUT_EN
    check("rerun_signature", {16'd0, signature}, {16'd0, GOLD});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bist_engine.md
BIST_ENGINE -- requirements
Module: bist_engine

Interface
REQ-001 SHALL have parameter N_CHAINS, default 2: number of scan chains driven and compacted.
REQ-002 SHALL have parameter CHAIN_LEN, default 16: flops per chain (shift cycles per pattern).
REQ-003 SHALL have parameter N_PATTERNS, default 256: pseudo-random patterns applied.
REQ-004 SHALL have parameters LFSR_W / LFSR_POLY / LFSR_SEED, defaults 16 / 16'hB400 / 16'h0001: pattern generator width, taps and nonzero seed (LFSR_W >= N_CHAINS).
REQ-005 SHALL have parameters MISR_W / MISR_POLY / GOLDEN_SIG, defaults 16 / 16'hB400 / 16'h0000: compactor width, taps and expected signature (MISR_W >= N_CHAINS).
REQ-006 SHALL have port CLK, input, 1: the single clock, rising edge.
REQ-007 SHALL have port RST, input, 1: asynchronous active-high reset.
REQ-008 SHALL have port bist_start, input, 1: level request to run a test.
REQ-009 SHALL have port scan_en, output, 1: 1 = chains shift, 0 = capture.
REQ-010 SHALL have port scan_in, output, N_CHAINS: serial data into the chains.
REQ-011 SHALL have port scan_out, input, N_CHAINS: serial data out of the chains.
REQ-012 SHALL have port bist_busy, output, 1: test in progress.
REQ-013 SHALL have port bist_end, output, 1: test complete, result valid.
REQ-014 SHALL have port pass_fail, output, 1: 1 = signature equals GOLDEN_SIG.

Function
REQ-015 SHALL implement FSM IDLE -> INIT -> SHIFT <-> CAPTURE -> UNLOAD -> COMPARE -> DONE -> IDLE.
REQ-016 SHALL leave IDLE only when bist_start is sampled high in IDLE; INIT lasts 1 cycle: LFSR = LFSR_SEED, MISR = 0, counters = 0.
REQ-017 SHALL in SHIFT drive scan_en = 1 and scan_in[i] = lfsr[i], advancing the Fibonacci LFSR once per cycle, for exactly CHAIN_LEN cycles.
REQ-018 SHALL in CAPTURE drive scan_en = 0 for exactly 1 cycle, then increment the pattern counter; SHIFT follows while count < N_PATTERNS, else UNLOAD.
REQ-019 SHALL in UNLOAD shift CHAIN_LEN cycles with scan_en = 1 and scan_in = 0 to flush the last response.
REQ-020 SHALL update the MISR each cycle the chains shift, except during the first pattern's shift: next = shifted MISR with MISR_POLY feedback XOR zero-extended scan_out.
REQ-021 SHALL in COMPARE (1 cycle) register pass_fail = (MISR == GOLDEN_SIG); DONE follows.
REQ-022 SHALL assert bist_end exactly 2 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN cycles after the edge sampling bist_start.
REQ-023 SHALL hold bist_end = 1 and pass_fail stable in DONE while bist_start = 1; on bist_start = 0, SHALL go to IDLE, clearing bist_end (pass_fail keeps its value until the next INIT).
REQ-024 SHALL assert bist_busy in INIT through COMPARE; bist_start changes during busy are ignored.
REQ-025 SHALL keep scan_en = 0 and scan_in = 0 in IDLE, COMPARE and DONE.

Reset
REQ-026 SHALL on RST = 1, at any state, immediately force IDLE, scan_en = 0, scan_in = 0, bist_busy = 0, bist_end = 0, pass_fail = 0, LFSR = LFSR_SEED, MISR = 0, counters = 0.
REQ-027 SHALL not start a run on the first edge after RST release unless bist_start is high.

Configuration
REQ-028 SHALL with BIST_SIG_OUT_EN defined add output signature [MISR_W] (live MISR, frozen from COMPARE until next INIT) and output pattern_cnt [$clog2(N_PATTERNS+1)]; without it those ports and their logic are absent and all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state typedef, default polynomial/seed constants and the latency formula function in package bist_pkg.
REQ-030 SHALL implement LFSR and MISR as one parametrised sub-module bist_lfsr (width, poly, parallel-input enable), instantiated twice.

Verification (N_CHAINS=2, CHAIN_LEN=4, N_PATTERNS=8, chains modelled as 4-flop shift registers)
REQ-031 SHALL cover: fault-free CUT, bist_start high at 300 ns -> bist_end rises 46 cycles later, pass_fail = 1 with GOLDEN_SIG from software model.
REQ-032 SHALL cover: chain 1 flop 2 stuck-at-0 -> bist_end after 46 cycles, pass_fail = 0.
REQ-033 SHALL cover: RST pulsed during the 3rd SHIFT -> all outputs 0 within the reset pulse; new bist_start rerun gives pass_fail = 1.
REQ-034 SHALL cover: bist_start held high after DONE -> no second run; drop then raise -> second run, identical result and latency.
REQ-035 SHALL cover: bist_start toggled during busy -> latency and result unchanged.
REQ-036 SHALL cover: with BIST_SIG_OUT_EN, signature == model value and pattern_cnt == 8 at bist_end.
